reg_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one tristated register-file data bus between NUM_REQ drivers.
- Produces one-hot, registered drive enables that feed each driver's TristateBuffer enable input, so at most one driver is ever active.
- Enforces a maximum tenure per grant and optionally inserts a bus-turnaround idle cycle between owners.
- Sits in Datapath/FileRegister, beside the register file and its output buffers.

---
 rtl/reg_bus_arbiter_pkg.sv | 16 +
 rtl/reg_bus_arb_defs.vh | 12 +
 rtl/rr_priority_pick.sv | 30 +++
 rtl/reg_bus_arbiter.sv | 118 +++++++++++
 tb/tb_reg_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
// Types and default constants for reg_bus_arbiter.
// Optional turnaround cycle is selected by the macro REG_BUS_ARB_TURNAROUND_EN.
`include "reg_bus_arb_defs.vh"

package reg_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_ST_IDLE  = `ARB_IDLE,
    ARB_ST_GRANT = `ARB_GRANT,
    ARB_ST_TURN  = `ARB_TURN
  } arb_state_e;

  localparam int DEF_NUM_REQ  = `REG_BUS_ARB_DEF_NUM_REQ;
  localparam int DEF_MAX_HOLD = `REG_BUS_ARB_DEF_MAX_HOLD;

endpackage

// File: rtl/reg_bus_arb_defs.vh
// Shared encodings and default sizing for the register-bus arbiter family.
`ifndef REG_BUS_ARB_DEFS_VH
`define REG_BUS_ARB_DEFS_VH

`define ARB_IDLE  2'd0
`define ARB_GRANT 2'd1
`define ARB_TURN  2'd2

`define REG_BUS_ARB_DEF_NUM_REQ  4
`define REG_BUS_ARB_DEF_MAX_HOLD 8

`endif

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
// Reusable by any shared-resource arbiter.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_any    = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    // Scan farthest-first so the candidate nearest to the pointer is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      int v_idx;
      v_idx = (int'(i_ptr) + k) % N;
      if (|(i_req & (N'(1) << v_idx))) begin
        o_any    = 1'b1;
        o_onehot = N'(1) << v_idx;
        o_idx    = IDX_W'(v_idx);
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin owner arbiter for the tristated register-file bus; grant flops drive buffer enables.
// Define REG_BUS_ARB_TURNAROUND_EN to insert one idle bus cycle between owners.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int ID_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] buf_en,
  output logic               busy,
  output logic [ID_W-1:0]    owner_id,
  output logic               forced_rel,
  output arb_state_e         o_dbg_state,
  output logic [ID_W-1:0]    o_dbg_rr_ptr
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [ID_W-1:0]     r_owner;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_forced;

  logic                w_owner_req;
  logic                w_expire;
  logic                w_release;
  logic [ID_W-1:0]     w_next_ptr;
  logic [ID_W-1:0]     w_pick_ptr;
  logic                w_any;
  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [ID_W-1:0]     w_pick_idx;

  // r_grant is one-hot while granted, so overlap with req is req[owner].
  assign w_owner_req = |(req & r_grant);
  assign w_expire    = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign w_release   = !w_owner_req || w_expire;
  assign w_next_ptr  = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  // A back-to-back handoff must search from past the departing owner.
  assign w_pick_ptr  = (r_state == ARB_ST_GRANT) ? w_next_ptr : r_rr_ptr;

  rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (w_pick_ptr),
    .o_any    (w_any),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_forced   <= 1'b0;
    end else begin
      r_forced <= 1'b0;
      case (r_state)
        ARB_ST_IDLE, ARB_ST_TURN: begin
          if (w_any) begin
            r_grant    <= w_pick_onehot;
            r_owner    <= w_pick_idx;
            r_hold_cnt <= '0;
            r_state    <= ARB_ST_GRANT;
          end else begin
            r_state    <= ARB_ST_IDLE;
          end
        end
        ARB_ST_GRANT: begin
          if (w_release) begin
            r_forced <= w_owner_req;
            r_rr_ptr <= w_next_ptr;
`ifdef REG_BUS_ARB_TURNAROUND_EN
            r_grant  <= '0;
            r_state  <= ARB_ST_TURN;
`else
            if (w_any) begin
              r_grant    <= w_pick_onehot;
              r_owner    <= w_pick_idx;
              r_hold_cnt <= '0;
            end else begin
              r_grant    <= '0;
              r_state    <= ARB_ST_IDLE;
            end
`endif
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ARB_ST_IDLE;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign buf_en       = r_grant;
  assign busy         = |r_grant;
  assign owner_id     = r_owner;
  assign forced_rel   = r_forced;
  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: three instances (MAX_HOLD 3, 2, 0) on one req bus,
// checked every cycle against a queue-free tenure model plus directed literal sequences.
module tb_reg_bus_arbiter;

  localparam int N  = 4;
  localparam int NI = 3;
  localparam int MH [NI] = '{3, 2, 0};

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;

  logic [N-1:0] grant    [NI];
  logic [N-1:0] buf_en   [NI];
  logic         busy     [NI];
  logic [1:0]   owner_id [NI];
  logic         forced   [NI];
  logic [1:0]   dbg_st   [NI];
  logic [1:0]   dbg_ptr  [NI];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < NI; g++) begin : g_dut
    reg_bus_arbiter #(
      .NUM_REQ  (N),
      .MAX_HOLD (MH[g]),
      .ID_W     (2)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .grant        (grant[g]),
      .buf_en       (buf_en[g]),
      .busy         (busy[g]),
      .owner_id     (owner_id[g]),
      .forced_rel   (forced[g]),
      .o_dbg_state  (dbg_st[g]),
      .o_dbg_rr_ptr (dbg_ptr[g])
    );
  end

  // ---------------- behavioural model ----------------
  // Tracks who owns the bus, how many cycles they have had, and where the next search starts.
  bit m_busy   [NI];
  int m_owner  [NI];
  int m_tenure [NI];
  int m_ptr    [NI];
  int m_oid    [NI];
  bit m_forced [NI];

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      m_busy[g] = 0; m_owner[g] = 0; m_tenure[g] = 0;
      m_ptr[g] = 0; m_oid[g] = 0; m_forced[g] = 0;
    end
  endtask

  task automatic model_grant(input int g, input int p);
    m_busy[g]   = 1;
    m_owner[g]  = p;
    m_oid[g]    = p;
    m_tenure[g] = 1;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    for (int g = 0; g < NI; g++) begin
      bit f;
      int p;
      f = 0;
      if (m_busy[g]) begin
        if (!r[m_owner[g]] || (MH[g] != 0 && m_tenure[g] >= MH[g])) begin
          f = r[m_owner[g]];
          m_ptr[g]  = (m_owner[g] + 1) % N;
          m_busy[g] = 0;
`ifndef REG_BUS_ARB_TURNAROUND_EN
          p = pick(r, m_ptr[g]);
          if (p >= 0) model_grant(g, p);
`endif
        end else begin
          m_tenure[g]++;
        end
      end else begin
        p = pick(r, m_ptr[g]);
        if (p >= 0) model_grant(g, p);
      end
      m_forced[g] = f;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(req);
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] prev_grant [NI];

  initial begin
    for (int g = 0; g < NI; g++) prev_grant[g] = '0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        logic [N-1:0] exp_g;
        exp_g = m_busy[g] ? (N'(1) << m_owner[g]) : '0;
        check($sformatf("grant[%0d]", g), 32'(grant[g]), 32'(exp_g));
        check($sformatf("buf_en[%0d]", g), 32'(buf_en[g]), 32'(grant[g]));
        check($sformatf("busy[%0d]", g), 32'(busy[g]), 32'(m_busy[g]));
        check($sformatf("owner_id[%0d]", g), 32'(owner_id[g]), 32'(m_oid[g]));
        check($sformatf("forced_rel[%0d]", g), 32'(forced[g]), 32'(m_forced[g]));
        check($sformatf("onehot0[%0d]", g), 32'($onehot0(grant[g])), 32'd1);
        if (busy[g])
          check($sformatf("owner_vs_grant[%0d]", g), 32'(grant[g]), 32'(N'(1) << owner_id[g]));
`ifdef REG_BUS_ARB_TURNAROUND_EN
        if (prev_grant[g] != '0 && grant[g] != '0)
          check($sformatf("adjacent_owner[%0d]", g), 32'(grant[g]), 32'(prev_grant[g]));
`endif
        prev_grant[g] = grant[g];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_grant(input int g, input logic [N-1:0] exp, input string nm);
    @(negedge clk);
    check($sformatf("%s grant[%0d]", nm, g), 32'(grant[g]), 32'(exp));
  endtask

  // ---------------- directed stimulus ----------------
  logic [N-1:0] rr_seq  [9];
  logic         rr_frc  [9];
  logic [N-1:0] ta_seq  [9];
  logic [N-1:0] pre_seq [4];

  initial begin
`ifdef REG_BUS_ARB_TURNAROUND_EN
    rr_seq  = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    rr_frc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pre_seq = '{4'b0100, 4'b0100, 4'b0000, 4'b0100};
`else
    rr_seq  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    rr_frc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pre_seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100};
`endif
    ta_seq  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};

    // reset values
    do_reset();
    #1;
    check("reset grant", 32'(grant[0]), 32'd0);
    check("reset owner_id", 32'(owner_id[0]), 32'd0);
    check("reset rr_ptr", 32'(dbg_ptr[0]), 32'd0);

    // asynchronous reset mid-tenure floats the bus before the next edge
    do_reset();
    req = 4'b0100;
    expect_grant(0, 4'b0100, "pre_reset");
    #1 rst_n = 1'b0;
    #1;
    check("async_rst grant", 32'(grant[0]), 32'd0);
    check("async_rst buf_en", 32'(buf_en[0]), 32'd0);
    check("async_rst busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0001;
    expect_grant(0, 4'b0001, "post_reset");
    check("post_reset owner_id", 32'(owner_id[0]), 32'd0);

    // round robin with MAX_HOLD=2, all requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      expect_grant(1, rr_seq[i], $sformatf("rr%0d", i));
      check($sformatf("rr%0d forced", i), 32'(forced[1]), 32'(rr_frc[i]));
    end

    // voluntary release then wrap from pointer 2
    do_reset();
    req = 4'b0010;
    expect_grant(0, 4'b0010, "vol0");
    expect_grant(0, 4'b0010, "vol1");
    expect_grant(0, 4'b0010, "vol2");
    req = 4'b0000;
    expect_grant(0, 4'b0000, "vol3");
    check("vol forced", 32'(forced[0]), 32'd0);
    check("vol rr_ptr", 32'(dbg_ptr[0]), 32'd2);
    req = 4'b0011;
    expect_grant(0, 4'b0001, "vol_wrap");

    // sole requester preempted by MAX_HOLD=2 is re-granted
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) expect_grant(1, pre_seq[i], $sformatf("preempt%0d", i));

`ifdef REG_BUS_ARB_TURNAROUND_EN
    // turnaround with MAX_HOLD=3
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 9; i++) expect_grant(0, ta_seq[i], $sformatf("turn%0d", i));
`endif

    // unlimited hold
    do_reset();
    req = 4'b1000;
    expect_grant(2, 4'b1000, "unl_start");
    req = 4'b1001;
    for (int i = 0; i < 50; i++) begin
      expect_grant(2, 4'b1000, "unl_hold");
      check("unl forced", 32'(forced[2]), 32'd0);
    end

    // random sweep, requests held for a few cycles at a time
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
    end

    req = '0;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
